prime_bench_seq: RTL
====================

# prime_bench_seq

Parametrised benchmark sequencer for the primogen prime generator on icestick-class boards. It repeatedly requests the next prime over primogen's go/ready handshake and counts the primes produced. It stops on a programmable prime count or on generator overflow, measures elapsed cycles, and drives an N-segment thermometer progress display. It sits between the board top level and one primogen instance.

## Interface
- WIDTH_LOG, 4: log2 of result width; W = 2**WIDTH_LOG.
- NLEDS, 4: progress segments; must be a power of two and at most W.
- CNT_W, 32: cycle-counter width.
- MAX_PRIMES, 0: stop after this many primes; 0 means run until overflow.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high. Primogen shares this reset.
- en  in  1  run enable; low pauses the sequencer after the prime in flight.
- pg_go  out  1  one-cycle request pulse to primogen.
- pg_ready  in  1  primogen idle / result valid.
- pg_error  in  1  primogen overflow; valid only with pg_ready.
- pg_res  in  W  primogen result.
- last_prime  out  W  most recent captured prime.
- prime_count  out  W  primes captured since reset.
- cycle_count  out  CNT_W  active cycles since reset.
- progress  out  NLEDS  thermometer of last_prime.
- done  out  1  MAX_PRIMES reached; sticky.
- overflow  out  1  pg_error seen; sticky.

## Operation
- States: IDLE, ISSUE, HOLD, WAIT, DONE, ERR. All outputs are registered.
- IDLE: move to ISSUE when en=1 and pg_ready=1.
- ISSUE: pg_go=1 for exactly this cycle, then move to HOLD.
- HOLD: pg_ready is ignored for one cycle, so primogen has a clock to register go and drop ready. Then move to WAIT.
- WAIT: act when pg_ready=1.
  - If pg_error=1: move to ERR and set overflow. Do not capture the result or increment the count.
  - Otherwise: last_prime <= pg_res and prime_count++.
  - If MAX_PRIMES != 0 and the new count equals MAX_PRIMES: move to DONE and set done.
  - Else if en=1: move to ISSUE.
  - Else: move to IDLE.
- DONE and ERR: terminal; leave only on rst. pg_go stays 0.
- en is sampled only in IDLE and at WAIT completion. Dropping en mid-request never aborts the request in flight.
- cycle_count increments in every cycle spent in ISSUE, HOLD or WAIT. It saturates at 2**CNT_W-1 and does not wrap.
- prime_count saturates at 2**W-1.
- progress[0] = (last_prime != 0).
- progress[i] = (last_prime >= i*2**W/NLEDS) for i = 1..NLEDS-1. Comparisons are unsigned. Constants are computed at W+1 bits, so there is no truncation.
- Simultaneous rst and pg_ready: rst wins; nothing is captured.

## Timing
- Reset values: state IDLE; pg_go, done and overflow 0; last_prime, prime_count, cycle_count and progress all 0.
- Reset mid-operation: all outputs return to reset values on the next edge. Any pg_go in progress is cut.
- pg_ready seen high in IDLE at edge t: pg_go is high during cycle t+1.
- WAIT completion at edge t:
  - last_prime, prime_count, progress, done and overflow update at that same edge.
  - The next pg_go is high during cycle t+1.
- Minimum request period is 3 cycles plus primogen busy time.
- pg_ready high during the pg_go cycle and the following cycle must never produce a second pulse or a second capture.

## Structure
- Shared package prime_bench_pkg holds:
  - the state enum (6 states, 3-bit encoding);
  - the segment-threshold function seg_thresh(i, W, NLEDS).
- Sub-module prime_bench_progress:
  - holds the registered thermometer decode of last_prime;
  - parameters WIDTH_LOG and NLEDS;
  - is kept separate so the segment count can be retargeted per board.
- The FSM and counters stay in prime_bench_seq.

## Test plan
Stimulus comes from a primogen model that returns successive primes. Its ready drops 1 cycle after pg_go and rises L=3 cycles later.
- MAX_PRIMES=5, en=1 -> exactly 5 pg_go pulses; last_prime 2,3,5,7,11; prime_count=5; done=1; cycle_count matches the bench's count of active cycles; no further pg_go.
- Model raises pg_error with ready on the 3rd request -> overflow=1, prime_count=2, last_prime=3, no further pg_go, state held until rst.
- WIDTH_LOG=4, NLEDS=4, forced captures -> last_prime 0 gives 0000; 2 gives 0001; 16383 gives 0001; 16384 gives 0011; 32768 gives 0111; 49152 gives 1111; 65521 gives 1111.
- en dropped during WAIT -> the in-flight prime is captured and no new pg_go follows; en raised -> pg_go resumes and prime_count continues from the held value.
- rst asserted for 1 cycle during WAIT -> all outputs 0 at the next edge and pg_go=0; after release the 5-prime run repeats identically.
- Model holds ready high in the pg_go cycle and the cycle after -> exactly one pg_go and one capture per request.

Source files
------------

// File: rtl/prime_bench_pkg.sv
// Shared types and constants for the primogen benchmark sequencer.
package prime_bench_pkg;

  // Sequencer states: one request walks ISSUE -> HOLD -> WAIT.
  // DONE and ERR are terminal until reset.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_HOLD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  // Lower bound of progress segment i: i * 2**w / nleds.
  // Evaluated in 64 bits, so the caller can keep w+1 bits without truncation.
  function automatic longint unsigned seg_thresh(input int unsigned i,
                                                 input int unsigned w,
                                                 input int unsigned nleds);
    longint unsigned full;
    full = 64'd1 << w;
    return (64'(i) * full) / 64'(nleds);
  endfunction

endpackage

// File: rtl/prime_bench_seq_if.sv
// Request/result handshake between the sequencer and one primogen instance.
//
// Handshake: the master pulses pg_go for one cycle to request the next prime.
// The slave holds pg_ready high while idle. It drops pg_ready no later than
// one cycle after pg_go, and raises it again with pg_res (and pg_error on
// overflow) valid. pg_res and pg_error are meaningful only while pg_ready=1.
interface prime_bench_seq_if #(
  parameter int WIDTH_LOG = 4
);
  localparam int W = 2**WIDTH_LOG;

  logic         pg_go;
  logic         pg_ready;
  logic         pg_error;
  logic [W-1:0] pg_res;

  modport master (output pg_go, input pg_ready, input pg_error, input pg_res);
  modport slave  (input pg_go, output pg_ready, output pg_error, output pg_res);
endinterface

// File: rtl/prime_bench_progress.sv
// Registered thermometer decode of the most recent prime. Kept separate so
// the segment count can be retargeted per board.
module prime_bench_progress
  import prime_bench_pkg::*;
#(
  parameter int WIDTH_LOG = 4,
  parameter int NLEDS     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2**WIDTH_LOG-1:0] value_d,
  output logic [NLEDS-1:0]        progress
);
  localparam int W = 2**WIDTH_LOG;

  logic [NLEDS-1:0] progress_d;
  logic [NLEDS-1:0] progress_q;

  // Segment 0 lights for any non-zero value.
  assign progress_d[0] = |value_d;

  // Segments 1..NLEDS-1 compare against W+1 bit thresholds, so the top
  // threshold never wraps.
  for (genvar g = 1; g < NLEDS; g++) begin : g_seg
    localparam logic [W:0] THRESH = (W+1)'(seg_thresh(g, W, NLEDS));
    assign progress_d[g] = ({1'b0, value_d} >= THRESH);
  end

  // Decode the next last_prime so the bar moves on the capture edge itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      progress_q <= '0;
    end else begin
      progress_q <= progress_d;
    end
  end

  assign progress = progress_q;

endmodule

// File: rtl/prime_bench_seq.sv
// Benchmark sequencer: requests primes from primogen back to back. It counts
// captured primes and active cycles, and stops on a prime budget or on
// generator overflow.
module prime_bench_seq
  import prime_bench_pkg::*;
#(
  parameter int WIDTH_LOG  = 4,
  parameter int NLEDS      = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_PRIMES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  prime_bench_seq_if.master       pg,
  output logic [2**WIDTH_LOG-1:0] last_prime,
  output logic [2**WIDTH_LOG-1:0] prime_count,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [NLEDS-1:0]        progress,
  output logic                    done,
  output logic                    overflow,
  output state_e                  state_dbg
);
  localparam int W = 2**WIDTH_LOG;
  localparam logic [W-1:0] MAX_W = W'(MAX_PRIMES);

  state_e           state_q, state_d;
  logic             go_q, go_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [W-1:0]     last_prime_q, last_prime_d;
  logic [W-1:0]     prime_count_q, prime_count_d;
  logic [W-1:0]     count_inc;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  // Next state, request pulse, result capture and saturating counters.
  always_comb begin
    state_d       = state_q;
    go_d          = 1'b0;
    done_d        = done_q;
    overflow_d    = overflow_q;
    last_prime_d  = last_prime_q;
    prime_count_d = prime_count_q;
    cycle_count_d = cycle_count_q;
    count_inc     = (prime_count_q == '1) ? prime_count_q : prime_count_q + W'(1);

    if ((state_q == ST_ISSUE || state_q == ST_HOLD || state_q == ST_WAIT) &&
        cycle_count_q != '1) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (en && pg.pg_ready) begin
          state_d = ST_ISSUE;
          go_d    = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_HOLD;
      // primogen gets this cycle to register go and drop ready.
      ST_HOLD:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (pg.pg_ready) begin
          if (pg.pg_error) begin
            state_d    = ST_ERR;
            overflow_d = 1'b1;
          end else begin
            last_prime_d  = pg.pg_res;
            prime_count_d = count_inc;
            if (MAX_PRIMES != 0 && count_inc == MAX_W) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else if (en) begin
              state_d = ST_ISSUE;
              go_d    = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      // DONE and ERR hold until reset.
      default: state_d = state_q;
    endcase
  end

  // State and output registers; reset cuts any pulse in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      go_q          <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      last_prime_q  <= '0;
      prime_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      go_q          <= go_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      last_prime_q  <= last_prime_d;
      prime_count_q <= prime_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  prime_bench_progress #(
    .WIDTH_LOG (WIDTH_LOG),
    .NLEDS     (NLEDS)
  ) u_progress (
    .clk      (clk),
    .rst      (rst),
    .value_d  (last_prime_d),
    .progress (progress)
  );

  assign pg.pg_go    = go_q;
  assign last_prime  = last_prime_q;
  assign prime_count = prime_count_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign state_dbg   = state_q;

endmodule
